uart_rx_fifo: RTL

Serial-receive stage sitting directly downstream of riscv_top's Tx pin: deserialises 8N1 UART frames into bytes and buffers them in a small first-word-fall-through FIFO. Serves as the bench-side console sink (bytes drained and printed by simulation) and as a synthesizable receiver for loopback on the FPGA target. Fully synchronous to one clock apart from the asynchronous reset; the serial input is asynchronous and synchronised internally.

---
 rtl/uart_rx_fifo_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Read-side bus of uart_rx_fifo: FWFT FIFO head, pop request, status and error pulses.
// With UART_RX_PARITY_EN defined the bus also carries parity_err.
interface uart_rx_fifo_if #(
   parameter int FIFO_AW = 3
);
   logic               rd_en_in;
   logic [7:0]         dout;
   logic               empty;
   logic               full;
   logic [FIFO_AW:0]   count;
   logic               frame_err;
   logic               overflow;
`ifdef UART_RX_PARITY_EN
   logic               parity_err;

   modport master (output rd_en_in,
                   input  dout, empty, full, count, frame_err, overflow, parity_err);
   modport slave  (input  rd_en_in,
                   output dout, empty, full, count, frame_err, overflow, parity_err);
`else
   modport master (output rd_en_in,
                   input  dout, empty, full, count, frame_err, overflow);
   modport slave  (input  rd_en_in,
                   output dout, empty, full, count, frame_err, overflow);
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a small
// first-word-fall-through FIFO; serial input is synchronised internally.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 3
) (
   input  logic          clk_in,
   input  logic          rst_n,
   input  logic          rx_in,
   uart_rx_fifo_if.slave bus
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CTR_W = $clog2(CLKS_PER_BIT);
   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLKS_PER_BIT - 1);
   localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t             state_q, state_d;
   logic               rx_meta_q, rx_meta_d;
   logic               rx_s_q, rx_s_d;
   logic               rx_prev_q, rx_prev_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d;
   logic [2:0]         idx_q, idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               frame_err_q, frame_err_d;
   logic               overflow_q, overflow_d;
   logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]         mem_q [DEPTH];
   logic [7:0]         mem_d [DEPTH];
   logic               push;
   logic               pop;
   logic [FIFO_AW:0]   count;
   logic               fifo_full;
   logic               fifo_empty;
`ifdef UART_RX_PARITY_EN
   logic               par_bad_q, par_bad_d;
   logic               parity_err_q, parity_err_d;
`endif

   always_comb begin
      rx_meta_d = rx_in;
      rx_s_d    = rx_meta_q;
      rx_prev_d = rx_s_q;
   end

   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q + CTR_W'(1);
      idx_d       = idx_q;
      shift_d     = shift_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            ctr_d = '0;
            if (!rx_s_q && rx_prev_q) state_d = START;
         end
         START: begin
            if (ctr_q == CTR_HALF) begin
               ctr_d = '0;
               if (!rx_s_q) begin
                  idx_d   = '0;
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (ctr_q == CTR_LAST) begin
               ctr_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
               if (idx_q == 3'd7) state_d = PARITY;
`else
               if (idx_q == 3'd7) state_d = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            // Even parity: the parity bit must equal the XOR of the data bits.
            if (ctr_q == CTR_LAST) begin
               ctr_d        = '0;
               par_bad_d    = (rx_s_q != ^shift_q);
               parity_err_d = par_bad_d;
               state_d      = STOP;
            end
         end
`endif
         STOP: begin
            if (ctr_q == CTR_LAST) begin
               ctr_d   = '0;
               state_d = IDLE;
               if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
                  push = !par_bad_q;
`else
                  push = 1'b1;
`endif
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count      = wr_ptr_q - rd_ptr_q;
      fifo_full  = (count == (FIFO_AW + 1)'(DEPTH));
      fifo_empty = (count == '0);
      pop        = bus.rd_en_in && !fifo_empty;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = push && fifo_full && !pop;
      // When full, a simultaneous pop frees the slot being written this edge.
      if (push && (!fifo_full || pop)) begin
         mem_d[wr_ptr_q[FIFO_AW-1:0]] = shift_q;
         wr_ptr_d = wr_ptr_q + (FIFO_AW + 1)'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + (FIFO_AW + 1)'(1);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_prev_q   <= 1'b1;
         ctr_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_q       <= '{default: '0};
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         rx_prev_q   <= rx_prev_d;
         ctr_q       <= ctr_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_q       <= mem_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= (state_q == IDLE) ? 1'b0 : par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign bus.dout      = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign bus.empty     = fifo_empty;
   assign bus.full      = fifo_full;
   assign bus.count     = count;
   assign bus.frame_err = frame_err_q;
   assign bus.overflow  = overflow_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`endif
endmodule
